// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry, the hard-wired zero register and
// the write-buffer entry layout.
package regfile_pkg;

    localparam int REG_COUNT = 16;
    localparam int REG_ID_W  = 4;
    localparam int DATA_W    = 16;

    localparam logic [REG_ID_W-1:0] R0_ID = 4'd0;

    typedef struct packed {
        logic                valid;
        logic [REG_ID_W-1:0] id;
        logic [DATA_W-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_write_ctrl_dec.sv
// 4-to-16 one-hot write wordline decoder; all-zero whenever en_i is low.
module WriteDecoder_4_16
    import regfile_pkg::*;
(
    input  logic [REG_ID_W-1:0]  id_i,
    input  logic                 en_i,
    output logic [REG_COUNT-1:0] wordline_o
);

    always_comb begin
        wordline_o = '0;
        if (en_i) begin
            wordline_o = REG_COUNT'(1) << id_i;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-side controller: in-order write buffer drained one entry
// per cycle into registered wordline/bitline outputs, with read-port bypass.
module regfile_write_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [REG_ID_W-1:0]  wr_id,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 array_busy,
    output logic [REG_COUNT-1:0] write_wordline,
    output logic [WIDTH-1:0]     bitline_data,
    output logic                 write_en,
    input  logic [REG_ID_W-1:0]  rd_id_a,
    input  logic [REG_ID_W-1:0]  rd_id_b,
    output logic                 byp_hit_a,
    output logic                 byp_hit_b,
    output logic [WIDTH-1:0]     byp_data_a,
    output logic [WIDTH-1:0]     byp_data_b
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [REG_ID_W-1:0]  id_q   [DEPTH];
    logic [WIDTH-1:0]     data_q [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [REG_COUNT-1:0] wordline_q, wordline_d;
    logic [WIDTH-1:0]     bitline_q, bitline_d;
    logic                 write_en_q, write_en_d;

    logic accept;
    logic push;
    logic pop;

    assign wr_ready = (count_q < DEPTH_C);
    assign accept   = wr_valid && wr_ready;
    // R0 is hard-wired zero: the request is acknowledged but never buffered.
    assign push     = accept && (wr_id != R0_ID);
    assign pop      = (count_q != '0) && !array_busy;

    WriteDecoder_4_16 u_dec (
        .id_i       (id_q[head_q]),
        .en_i       (pop),
        .wordline_o (wordline_d)
    );

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        bitline_d  = '0;
        write_en_d = pop;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
            bitline_d       = data_q[head_q];
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wordline_q <= '0;
            bitline_q  <= '0;
            write_en_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wordline_q <= wordline_d;
            bitline_q  <= bitline_d;
            write_en_q <= write_en_d;
        end
    end

    // Payload storage needs no reset; valid_q guards every use.
    always_ff @(posedge clk) begin
        if (push) begin
            id_q[tail_q]   <= wr_id;
            data_q[tail_q] <= wr_data;
        end
    end

    assign write_wordline = wordline_q;
    assign bitline_data   = bitline_q;
    assign write_en       = write_en_q;

    // Candidates scanned oldest first (output register, then head..tail) so
    // the last match is the youngest.
    function automatic logic [WIDTH:0] bypass_lookup(input logic [REG_ID_W-1:0] rd_id);
        logic             hit;
        logic [WIDTH-1:0] data;
        logic [PTR_W-1:0] idx;
        hit  = 1'b0;
        data = '0;
        if (rd_id != R0_ID) begin
            if (wordline_q[rd_id]) begin
                hit  = 1'b1;
                data = bitline_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_q + PTR_W'(k);
                if (valid_q[idx] && (id_q[idx] == rd_id)) begin
                    hit  = 1'b1;
                    data = data_q[idx];
                end
            end
        end
        return {hit, data};
    endfunction

    assign {byp_hit_a, byp_data_a} = bypass_lookup(rd_id_a);
    assign {byp_hit_b, byp_data_b} = bypass_lookup(rd_id_b);

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl with a write scoreboard checked at
// every array strobe.
module tb_regfile_write_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_id;
    logic [15:0] wr_data;
    logic        array_busy;
    logic [15:0] write_wordline;
    logic [15:0] bitline_data;
    logic        write_en;
    logic [3:0]  rd_id_a;
    logic [3:0]  rd_id_b;
    logic        byp_hit_a;
    logic        byp_hit_b;
    logic [15:0] byp_data_a;
    logic [15:0] byp_data_b;

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   n_strobe = 0;
    int   s0;

    regfile_write_ctrl #(.DEPTH(2), .WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_id          (wr_id),
        .wr_data        (wr_data),
        .array_busy     (array_busy),
        .write_wordline (write_wordline),
        .bitline_data   (bitline_data),
        .write_en       (write_en),
        .rd_id_a        (rd_id_a),
        .rd_id_b        (rd_id_b),
        .byp_hit_a      (byp_hit_a),
        .byp_hit_b      (byp_hit_b),
        .byp_data_a     (byp_data_a),
        .byp_data_b     (byp_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [3:0] id, input logic [15:0] d);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_id    = id;
        wr_data  = d;
        while (!wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            chk("send_timeout", {31'b0, wr_ready}, 32'd1);
        end else begin
            if (id != 4'd0) sb.push_back('{id: id, data: d});
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && write_en) begin
            n_strobe++;
            if (sb.size() == 0) begin
                chk("stale_strobe", {16'b0, write_wordline}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_wordline", {16'b0, write_wordline}, {16'b0, 16'h1 << mon_e.id});
                chk("sb_bitline", {16'b0, bitline_data}, {16'b0, mon_e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        wr_valid   = 1'b0;
        wr_id      = 4'd0;
        wr_data    = 16'h0;
        array_busy = 1'b0;
        rd_id_a    = 4'd0;
        rd_id_b    = 4'd0;
        #1;
        chk("rst_ready", {31'b0, wr_ready}, 32'd1);
        chk("rst_we", {31'b0, write_en}, 32'd0);
        chk("rst_wl", {16'b0, write_wordline}, 32'd0);
        chk("rst_bl", {16'b0, bitline_data}, 32'd0);
        chk("rst_hit_a", {31'b0, byp_hit_a}, 32'd0);
        chk("rst_byp_b", {15'b0, byp_hit_b, byp_data_b}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single write, one-cycle latency, single strobe
        send(4'd5, 16'hBEEF);
        chk("t1_c0_we", {31'b0, write_en}, 32'd0);
        @(negedge clk);
        chk("t1_c1_wl", {16'b0, write_wordline}, 32'h0020);
        chk("t1_c1_bl", {16'b0, bitline_data}, 32'hBEEF);
        chk("t1_c1_we", {31'b0, write_en}, 32'd1);
        @(negedge clk);
        chk("t1_c2_wl", {16'b0, write_wordline}, 32'd0);
        chk("t1_c2_bl", {16'b0, bitline_data}, 32'd0);
        chk("t1_c2_we", {31'b0, write_en}, 32'd0);

        // R0 discard
        rd_id_a = 4'd0;
        send(4'd0, 16'h1234);
        repeat (3) begin
            chk("t2_we", {31'b0, write_en}, 32'd0);
            chk("t2_hit_a", {31'b0, byp_hit_a}, 32'd0);
            @(negedge clk);
        end

        // backpressure and full buffer
        array_busy = 1'b1;
        send(4'd3, 16'hAAAA);
        send(4'd7, 16'hBBBB);
        chk("t3_full_ready", {31'b0, wr_ready}, 32'd0);
        wr_valid = 1'b1;
        wr_id    = 4'd12;
        wr_data  = 16'hCCCC;
        repeat (2) begin
            @(negedge clk);
            chk("t3_stall_ready", {31'b0, wr_ready}, 32'd0);
            chk("t3_busy_we", {31'b0, write_en}, 32'd0);
        end
        array_busy = 1'b0;
        @(negedge clk);
        chk("t3_wl_first", {16'b0, write_wordline}, 32'h0008);
        chk("t3_ready_back", {31'b0, wr_ready}, 32'd1);
        sb.push_back('{id: 4'd12, data: 16'hCCCC});
        @(negedge clk);
        wr_valid = 1'b0;
        chk("t3_wl_second", {16'b0, write_wordline}, 32'h0080);
        @(negedge clk);
        chk("t3_wl_third", {16'b0, write_wordline}, 32'h1000);
        @(negedge clk);
        chk("t3_idle_we", {31'b0, write_en}, 32'd0);

        // same-id ordering and youngest-wins bypass
        array_busy = 1'b1;
        rd_id_b    = 4'd9;
        send(4'd9, 16'h0001);
        chk("t4_hit_b1", {31'b0, byp_hit_b}, 32'd1);
        chk("t4_data_b1", {16'b0, byp_data_b}, 32'h0001);
        send(4'd9, 16'h0002);
        chk("t4_hit_b2", {31'b0, byp_hit_b}, 32'd1);
        chk("t4_data_b2", {16'b0, byp_data_b}, 32'h0002);
        array_busy = 1'b0;
        @(negedge clk);
        chk("t4_bl_old", {16'b0, bitline_data}, 32'h0001);
        chk("t4_data_b_young", {16'b0, byp_data_b}, 32'h0002);
        @(negedge clk);
        chk("t4_hit_b_outreg", {31'b0, byp_hit_b}, 32'd1);
        chk("t4_data_b_outreg", {16'b0, byp_data_b}, 32'h0002);
        @(negedge clk);
        chk("t4_hit_b_gone", {31'b0, byp_hit_b}, 32'd0);

        // accept not visible to bypass same cycle, then push/pop streaming with wrap
        s0         = n_strobe;
        array_busy = 1'b1;
        rd_id_a    = 4'd4;
        wr_valid   = 1'b1;
        wr_id      = 4'd4;
        wr_data    = 16'h5555;
        #1;
        chk("t5_hit_same_cycle", {31'b0, byp_hit_a}, 32'd0);
        sb.push_back('{id: 4'd4, data: 16'h5555});
        @(negedge clk);
        wr_valid = 1'b0;
        chk("t5_hit_next_cycle", {31'b0, byp_hit_a}, 32'd1);
        chk("t5_data_next_cycle", {16'b0, byp_data_a}, 32'h5555);
        send(4'd11, 16'h0B0B);
        array_busy = 1'b0;
        send(4'd13, 16'h0D0D);
        send(4'd14, 16'h0E0E);
        repeat (4) @(negedge clk);
        chk("t5_sb_empty", sb.size(), 32'd0);
        chk("t5_strobes", n_strobe - s0, 32'd4);

        // async reset mid-drain
        array_busy = 1'b1;
        send(4'd6, 16'h0606);
        send(4'd8, 16'h0808);
        rd_id_a    = 4'd8;
        array_busy = 1'b0;
        @(negedge clk);
        chk("t6_we_before", {31'b0, write_en}, 32'd1);
        chk("t6_wl_before", {16'b0, write_wordline}, 32'h0040);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we", {31'b0, write_en}, 32'd0);
        chk("t6_rst_wl", {16'b0, write_wordline}, 32'd0);
        chk("t6_rst_bl", {16'b0, bitline_data}, 32'd0);
        chk("t6_rst_ready", {31'b0, wr_ready}, 32'd1);
        chk("t6_rst_hit_a", {31'b0, byp_hit_a}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_no_stale_we", {31'b0, write_en}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
